// File: rtl/instruction_memory_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instruction_memory_pipe: instruction RAM with a pipelined fetch    |
// | port and a drain-then-load program loader.          Revision 1.0   |
// +--------------------------------------------------------------------+
module instruction_memory_pipe #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 8,
  parameter int                LATENCY  = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_fault,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_busy,
  output logic [ADDR_W:0]   load_count
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] req_idx;
  logic              req_oor;
  logic              advance;
  logic              accept;
  logic              pipe_empty;
  logic              pipe_drains;
  logic              start_load;
  logic              write_en;

  assign req_idx   = req_addr[ADDR_W-1:0];
  assign req_oor   = |req_addr[31:ADDR_W];
  assign advance   = !rsp_valid || rsp_ready;
  assign req_ready = (state == SERVE) && !load_start && advance;
  assign accept    = req_valid && req_ready;
  assign write_en  = (state == LOAD) && load_valid && !reset;
  assign load_busy = (state != SERVE);

  // The whole pipeline moves as one: every stage holds while the output stalls.
  generate
    if (LATENCY == 1) begin : g_lat1
      assign pipe_empty  = !rsp_valid;
      assign pipe_drains = advance;

      always_ff @(posedge clock) begin
        if (reset) begin
          rsp_valid <= 1'b0;
          rsp_data  <= '0;
          rsp_fault <= 1'b0;
        end else if (advance) begin
          rsp_valid <= accept;
          if (accept) begin
            rsp_data  <= req_oor ? NOP_WORD : mem[req_idx];
            rsp_fault <= req_oor;
          end
        end
      end
    end else begin : g_lat2
      logic              s1_valid;
      logic [ADDR_W-1:0] s1_idx;
      logic              s1_oor;

      assign pipe_empty  = !rsp_valid && !s1_valid;
      assign pipe_drains = advance && !s1_valid;

      always_ff @(posedge clock) begin
        if (reset) begin
          s1_valid  <= 1'b0;
          s1_idx    <= '0;
          s1_oor    <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_data  <= '0;
          rsp_fault <= 1'b0;
        end else if (advance) begin
          s1_valid  <= accept;
          if (accept) begin
            s1_idx <= req_idx;
            s1_oor <= req_oor;
          end
          rsp_valid <= s1_valid;
          if (s1_valid) begin
            rsp_data  <= s1_oor ? NOP_WORD : mem[s1_idx];
            rsp_fault <= s1_oor;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    next_state = state;
    start_load = 1'b0;
    case (state)
      SERVE: begin
        if (load_start) begin
          if (pipe_empty) begin
            next_state = LOAD;
            start_load = 1'b1;
          end else begin
            next_state = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pipe_drains) begin
          next_state = LOAD;
          start_load = 1'b1;
        end
      end
      LOAD: begin
        if (load_valid && (load_last || (&ptr))) begin
          next_state = SERVE;
        end
      end
      default: next_state = SERVE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= SERVE;
    end else begin
      state <= next_state;
    end
  end

  // The pointer saturates at the last word; the load ends there anyway.
  always_ff @(posedge clock) begin
    if (reset || start_load) begin
      ptr        <= '0;
      load_count <= '0;
    end else if (write_en) begin
      load_count <= load_count + 1'b1;
      if (!(&ptr)) begin
        ptr <= ptr + 1'b1;
      end
    end
  end

  // Storage deliberately has no reset so a program survives a core reset.
  always_ff @(posedge clock) begin
    if (write_en) begin
      mem[ptr] <= load_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_memory_pipe.sv
`default_nettype none
// Bench for instruction_memory_pipe: LATENCY=1 and LATENCY=2 instances checked
// every cycle against a queue-based transaction model.
module tb_instruction_memory_pipe;

  localparam int             DW      = 32;
  localparam int             AW      = 8;
  localparam int             DEPTH   = 256;
  localparam int             SBN     = 4096;
  localparam logic [DW-1:0]  NOP     = 32'hDEAD_BEEF;
  localparam int             M_SERVE = 0;
  localparam int             M_DRAIN = 1;
  localparam int             M_LOAD  = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          req_valid  [2];
  logic [31:0]   req_addr   [2];
  logic          rsp_ready  [2];
  logic          load_start [2];
  logic          load_valid [2];
  logic [DW-1:0] load_data  [2];
  logic          load_last  [2];
  logic          req_ready  [2];
  logic          rsp_valid  [2];
  logic [DW-1:0] rsp_data   [2];
  logic          rsp_fault  [2];
  logic          load_busy  [2];
  logic [AW:0]   load_count [2];

  instruction_memory_pipe #(.DATA_W(DW), .ADDR_W(AW), .LATENCY(1), .NOP_WORD(NOP)) u_dut_l1 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .rsp_fault(rsp_fault[0]), .load_start(load_start[0]), .load_valid(load_valid[0]),
    .load_data(load_data[0]), .load_last(load_last[0]), .load_busy(load_busy[0]),
    .load_count(load_count[0])
  );

  instruction_memory_pipe #(.DATA_W(DW), .ADDR_W(AW), .LATENCY(2), .NOP_WORD(NOP)) u_dut_l2 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .rsp_fault(rsp_fault[1]), .load_start(load_start[1]), .load_valid(load_valid[1]),
    .load_data(load_data[1]), .load_last(load_last[1]), .load_busy(load_busy[1]),
    .load_count(load_count[1])
  );

  // Reference model: loader mode, write pointer, word count, memory image and
  // an in-order queue of outstanding responses with their pipeline age.
  int            mode     [2];
  int            ptr_m    [2];
  int            cnt_m    [2];
  bit            model_on [2];
  logic [DW-1:0] mem_m    [2][DEPTH];
  logic [DW-1:0] sb_data  [2][SBN];
  logic          sb_fault [2][SBN];
  int            sb_age   [2][SBN];
  int            sb_head  [2];
  int            sb_tail  [2];
  int            checks;
  int            errors;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_load_m(input int d);
    mode[d]  = M_LOAD;
    ptr_m[d] = 0;
    cnt_m[d] = 0;
  endtask

  // Compare one DUT against the model, then advance the model across the coming edge.
  task automatic eval_dut(input int d);
    logic        ov, adv, rr_exp, acc, empty_now;
    logic [31:0] a;
    string       p;
    p         = $sformatf("L%0d", d + 1);
    empty_now = (sb_head[d] == sb_tail[d]);
    ov        = !empty_now && (sb_age[d][sb_head[d]] == d + 1);
    adv       = !ov || rsp_ready[d];
    rr_exp    = (mode[d] == M_SERVE) && !load_start[d] && adv;
    if (model_on[d]) begin
      check({p, " rsp_valid"}, rsp_valid[d], ov);
      if (ov) begin
        check({p, " rsp_data"}, rsp_data[d], sb_data[d][sb_head[d]]);
        check({p, " rsp_fault"}, rsp_fault[d], sb_fault[d][sb_head[d]]);
      end
      check({p, " req_ready"}, req_ready[d], rr_exp);
      check({p, " load_busy"}, load_busy[d], (mode[d] != M_SERVE));
      check({p, " load_count"}, load_count[d], cnt_m[d]);
    end
    if (reset) begin
      mode[d]     = M_SERVE;
      ptr_m[d]    = 0;
      cnt_m[d]    = 0;
      sb_head[d]  = sb_tail[d];
      model_on[d] = 1'b1;
      return;
    end
    if (!model_on[d]) return;
    acc = req_valid[d] && rr_exp;
    if (adv) begin
      if (ov) sb_head[d]++;
      for (int i = sb_head[d]; i < sb_tail[d]; i++) sb_age[d][i]++;
    end
    if (acc) begin
      a = req_addr[d];
      if (a[31:AW] != '0) begin
        sb_data[d][sb_tail[d]]  = NOP;
        sb_fault[d][sb_tail[d]] = 1'b1;
      end else begin
        sb_data[d][sb_tail[d]]  = mem_m[d][a[AW-1:0]];
        sb_fault[d][sb_tail[d]] = 1'b0;
      end
      sb_age[d][sb_tail[d]] = 1;
      sb_tail[d]++;
    end
    case (mode[d])
      M_SERVE: if (load_start[d]) begin
        if (empty_now) start_load_m(d);
        else mode[d] = M_DRAIN;
      end
      M_DRAIN: if (sb_head[d] == sb_tail[d]) start_load_m(d);
      default: if (load_valid[d]) begin
        mem_m[d][ptr_m[d]] = load_data[d];
        cnt_m[d]++;
        if (load_last[d] || ptr_m[d] == DEPTH - 1) mode[d] = M_SERVE;
        else ptr_m[d]++;
      end
    endcase
  endtask

  task automatic tick();
    @(negedge clock);
    for (int d = 0; d < 2; d++) eval_dut(d);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int d);
    req_valid[d]  = 1'b0;
    req_addr[d]   = '0;
    rsp_ready[d]  = 1'b1;
    load_start[d] = 1'b0;
    load_valid[d] = 1'b0;
    load_data[d]  = '0;
    load_last[d]  = 1'b0;
  endtask

  task automatic fetch(input int d, input logic [31:0] a);
    req_valid[d] = 1'b1;
    req_addr[d]  = a;
    tick();
    req_valid[d] = 1'b0;
  endtask

  task automatic load_word(input int d, input logic [DW-1:0] w, input logic last);
    load_valid[d] = 1'b1;
    load_data[d]  = w;
    load_last[d]  = last;
    tick();
    load_valid[d] = 1'b0;
    load_last[d]  = 1'b0;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    idle(d);
    while ((sb_head[d] != sb_tail[d] || mode[d] != M_SERVE) && n < 60) begin
      load_valid[d] = (mode[d] == M_LOAD);
      load_last[d]  = load_valid[d];
      load_data[d]  = $urandom;
      tick();
      n++;
    end
    idle(d);
    check($sformatf("L%0d drain bound", d + 1), (n < 60), 1'b1);
  endtask

  task automatic run_scenarios(input int d);
    logic [DW-1:0] first_word, w1;
    string         p;
    p = $sformatf("L%0d", d + 1);

    // Full-depth load without load_last: ends after address 255, no wrap.
    load_start[d] = 1'b1;
    tick();
    load_start[d] = 1'b0;
    first_word = $urandom;
    load_word(d, first_word, 1'b0);
    for (int i = 1; i < DEPTH; i++) load_word(d, $urandom, 1'b0);
    load_word(d, ~first_word, 1'b0);
    #2;
    check({p, " full load_count"}, load_count[d], 9'd256);
    check({p, " full load_busy"}, load_busy[d], 1'b0);
    fetch(d, 32'd0);
    repeat (3) tick();

    // Three-word program, then back-to-back fetches.
    load_start[d] = 1'b1;
    tick();
    load_start[d] = 1'b0;
    load_word(d, 32'h11, 1'b0);
    load_word(d, 32'h22, 1'b0);
    load_word(d, 32'h33, 1'b1);
    #2;
    check({p, " prog load_count"}, load_count[d], 9'd3);
    req_valid[d] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr[d] = i;
      tick();
    end
    req_valid[d] = 1'b0;
    repeat (3) tick();

    // Out-of-range fetches.
    fetch(d, 32'h0000_0100);
    fetch(d, 32'hFFFF_FF02);
    fetch(d, 32'd2);
    repeat (3) tick();

    // Back-pressure with responses pending.
    rsp_ready[d] = 1'b0;
    req_valid[d] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_addr[d] = 3 + i;
      tick();
    end
    #2;
    check({p, " bp req_ready"}, req_ready[d], 1'b0);
    check({p, " bp rsp_valid"}, rsp_valid[d], 1'b1);
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    repeat (4) tick();

    // load_start colliding with a request while responses are in flight.
    req_valid[d] = 1'b1;
    req_addr[d]  = 6;
    tick();
    req_addr[d]  = 7;
    tick();
    req_addr[d]   = 8;
    load_start[d] = 1'b1;
    #2;
    check({p, " collide req_ready"}, req_ready[d], 1'b0);
    tick();
    req_valid[d]  = 1'b0;
    load_start[d] = 1'b0;
    repeat (3) tick();
    #2;
    check({p, " collide load_busy"}, load_busy[d], 1'b1);
    load_word(d, 32'h55, 1'b1);
    #2;
    check({p, " collide load_count"}, load_count[d], 9'd1);
    fetch(d, 32'd0);
    repeat (3) tick();

    // Randomized traffic, including in-range/out-of-range mixes and loads.
    for (int c = 0; c < 400; c++) begin
      req_valid[d]  = ($urandom_range(2) != 0);
      req_addr[d]   = ($urandom_range(7) == 0) ? $urandom : 32'($urandom_range(255));
      rsp_ready[d]  = ($urandom_range(3) != 0);
      load_start[d] = ($urandom_range(49) == 0);
      load_valid[d] = ($urandom_range(1) != 0);
      load_data[d]  = $urandom;
      load_last[d]  = ($urandom_range(7) == 0);
      tick();
    end
    drain(d);

    // Reset in the middle of a load keeps the words already written.
    load_start[d] = 1'b1;
    tick();
    load_start[d] = 1'b0;
    load_word(d, $urandom, 1'b0);
    w1 = $urandom;
    load_word(d, w1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    check({p, " rst load_count"}, load_count[d], 9'd0);
    check({p, " rst load_busy"}, load_busy[d], 1'b0);
    check({p, " rst req_ready"}, req_ready[d], 1'b1);
    check({p, " rst model word1"}, mem_m[d][1], w1);
    fetch(d, 32'd1);
    repeat (3) tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int d = 0; d < 2; d++) begin
      idle(d);
      mode[d]     = M_SERVE;
      ptr_m[d]    = 0;
      cnt_m[d]    = 0;
      model_on[d] = 1'b0;
      sb_head[d]  = 0;
      sb_tail[d]  = 0;
    end
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("L%0d reset rsp_valid", d + 1), rsp_valid[d], 1'b0);
      check($sformatf("L%0d reset rsp_fault", d + 1), rsp_fault[d], 1'b0);
      check($sformatf("L%0d reset rsp_data", d + 1), rsp_data[d], 32'd0);
      check($sformatf("L%0d reset load_count", d + 1), load_count[d], 9'd0);
      check($sformatf("L%0d reset load_busy", d + 1), load_busy[d], 1'b0);
      check($sformatf("L%0d reset req_ready", d + 1), req_ready[d], 1'b1);
    end
    for (int d = 0; d < 2; d++) begin
      run_scenarios(d);
      drain(d);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
